// File: rtl/reg_file_dumper.sv
// Walks the register file through one shared read port and streams {address, data}
// words on a valid/ready interface for debug and trace capture.
module reg_file_dumper #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [ADDRESS_WIDTH-1:0] dout_addr,
    output logic [DATA_WIDTH-1:0]    dout_data,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(NUM_REGS - 1);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   last_word;

    // rd_addr doubles as the walk counter; it only moves on IDLE->READ and SEND->READ
    assign accept    = dout_valid && dout_ready;
    assign last_word = (rd_addr == LAST_ADDR);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = READ;
            READ: state_next = SEND;
            SEND: begin
                if (accept) state_next = last_word ? DONE : READ;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // busy and done are registered from the next state so they line up with the state itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr    <= '0;
            dout_valid <= 1'b0;
            dout_addr  <= '0;
            dout_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) rd_addr <= '0;
                end
                READ: begin
                    dout_data  <= rd_data;
                    dout_addr  <= rd_addr;
                    dout_valid <= 1'b1;
                end
                SEND: begin
                    if (accept) begin
                        dout_valid <= 1'b0;
                        if (!last_word) rd_addr <= rd_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_dumper.sv
// Scoreboard bench for reg_file_dumper: a behavioural register file answers the read
// port while directed dumps exercise backpressure, ignored starts, writes and abort.
module tb_reg_file_dumper;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NUM = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          dout_valid;
    logic          dout_ready;
    logic [AW-1:0] dout_addr;
    logic [DW-1:0] dout_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NUM];
    logic [63:0]   expq [$];
    int            checks;
    int            errors;

    reg_file_dumper #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .NUM_REGS     (NUM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_addr (dout_addr),
        .dout_data (dout_data),
        .busy      (busy),
        .done      (done)
    );

    assign rd_data = regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One dump from a start pulse; a negative argument disables that feature.
    task automatic applyStimulus(input int stallWord, input int stallCycles, input int pokeWord,
                                 input int writeWord, input int abortWord);
        int          cyc;
        int          words;
        int          dones;
        int          doneCyc;
        int          lastAccept;
        int          stalled;
        bit          haveHeld;
        bit          doneSeen;
        bit          finished;
        bit          aborted;
        logic [63:0] held;
        logic [63:0] exp;

        words = 0; dones = 0; doneCyc = -1; lastAccept = 0; stalled = 0;
        haveHeld = 0; doneSeen = 0; finished = 0; aborted = 0; held = '0;
        for (int i = 0; i < NUM; i++) regs[i] = 32'hA5A50000 + DW'(i);
        for (int i = 0; i < NUM; i++)
            expq.push_back({32'(i), (i == writeWord) ? 32'hDEADBEEF : regs[i]});

        @(negedge clk);
        start = 1'b1;
        dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc < 400 && !finished; cyc++) begin
            if (doneSeen) begin
                checkOutput("busy_after_done", 64'(busy), 64'd0);
                finished = 1;
            end
            if (done) begin
                dones++;
                doneCyc = cyc;
                doneSeen = 1;
            end
            start = (pokeWord >= 0) && dout_valid && (dout_addr == AW'(pokeWord));
            if (dout_valid) begin
                if (!haveHeld) begin
                    held = {32'(dout_addr), dout_data};
                    haveHeld = 1;
                    if (words == 0) checkOutput("first_valid_latency", 64'(cyc), 64'd2);
                end else begin
                    checkOutput("hold_stable", {32'(dout_addr), dout_data}, held);
                end
                if (abortWord >= 0 && dout_addr == AW'(abortWord)) begin
                    aborted = 1;
                    break;
                end
                if (stallWord >= 0 && dout_addr == AW'(stallWord) && stalled < stallCycles) begin
                    dout_ready = 1'b0;
                    stalled++;
                end else begin
                    dout_ready = 1'b1;
                    exp = (expq.size() > 0) ? expq.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
                    checkOutput("word", {32'(dout_addr), dout_data}, exp);
                    if (words > 0)
                        checkOutput("word_gap", 64'(cyc - lastAccept),
                                    64'(2 + ((stallWord >= 0 && dout_addr == AW'(stallWord)) ? stallCycles : 0)));
                    lastAccept = cyc;
                    words++;
                    haveHeld = 0;
                    if (writeWord > 0 && dout_addr == AW'(writeWord - 1)) regs[writeWord] = 32'hDEADBEEF;
                    if (writeWord >= 0 && dout_addr == AW'(writeWord)) regs[writeWord] = 32'h0BAD0BAD;
                end
            end else begin
                dout_ready = cyc[0];
            end
            @(negedge clk);
        end
        start = 1'b0;

        if (abortWord >= 0) begin
            checkOutput("abort_reached", 64'(aborted), 64'd1);
            #2 rst = 1'b1;
            #1;
            checkOutput("abort_valid_drop", 64'(dout_valid), 64'd0);
            checkOutput("abort_busy_drop", 64'(busy), 64'd0);
            checkOutput("abort_rd_addr", 64'(rd_addr), 64'd0);
            @(posedge clk);
            #1;
            checkOutput("abort_no_done", 64'(done), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            expq.delete();
            dout_ready = 1'b1;
        end else begin
            checkOutput("dump_finished", 64'(finished), 64'd1);
            checkOutput("word_count", 64'(words), 64'(NUM));
            checkOutput("done_count", 64'(dones), 64'd1);
            checkOutput("done_cycle", 64'(doneCyc), 64'(2 * NUM + 1 + stalled));
            checkOutput("queue_empty", 64'(expq.size()), 64'd0);
        end
    endtask

    initial begin
        int idleDones;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        dout_ready = 1'b0;
        for (int i = 0; i < NUM; i++) regs[i] = '0;

        $display("[TB] reset and idle");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idleDones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) idleDones++;
        end
        checkOutput("idle_rd_addr", 64'(rd_addr), 64'd0);
        checkOutput("idle_valid", 64'(dout_valid), 64'd0);
        checkOutput("idle_dout_addr", 64'(dout_addr), 64'd0);
        checkOutput("idle_dout_data", 64'(dout_data), 64'd0);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_done_pulses", 64'(idleDones), 64'd0);

        $display("[TB] full dump, no backpressure");
        applyStimulus(-1, 0, -1, -1, -1);
        repeat (3) @(negedge clk);

        $display("[TB] backpressure on word 3, start ignored at word 10");
        applyStimulus(3, 7, 10, -1, -1);
        repeat (3) @(negedge clk);

        $display("[TB] concurrent write to reg 5");
        applyStimulus(-1, 0, -1, 5, -1);
        repeat (3) @(negedge clk);

        $display("[TB] async reset while word 12 is valid");
        applyStimulus(-1, 0, -1, -1, 12);
        repeat (2) @(negedge clk);

        $display("[TB] dump after abort restarts at address 0");
        applyStimulus(-1, 0, -1, -1, -1);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
